// File: rtl/counter_pkg.sv
// Shared mode and state encodings for the contador counter and its command sequencer.
package counter_pkg;

    typedef enum logic [1:0] {
        COUNT_UP     = 2'b00,
        COUNT_DOWN   = 2'b01,
        COUNT_3_DOWN = 2'b10,
        CHARGE       = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        LOAD,
        VERIFY,
        RUN,
        SETTLE,
        DONE
    } state_t;

endpackage

// File: rtl/counter_sequencer_if.sv
// Requester-side command/response handshake of the counter sequencer.
interface counter_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_q;
    logic [7:0]       rsp_rco;
    logic             rsp_err;
    logic             busy;

    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_q, rsp_rco, rsp_err, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_q, rsp_rco, rsp_err, busy
    );
endinterface

// File: rtl/counter_expect.sv
// Combinational value a healthy counter should hold after N steps in a given mode.
module counter_expect
    import counter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  mode_t            op,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] expected
);

    always_comb begin
        // NOTE: default assignment first so no path leaves expected unassigned (no latch).
        expected = n;
        case (op)
            COUNT_UP:     expected = base + n;
            COUNT_DOWN:   expected = base - n;
            COUNT_3_DOWN: expected = base - n * WIDTH'(3);
            default:      expected = n;
        endcase
    end

endmodule

// File: rtl/counter_sequencer.sv
// Accepts load/count commands, drives the contador inputs, then reports final Q, RCO edges and a check flag.
module counter_sequencer
    import counter_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int CNT_LAT      = 2,
    parameter int LOAD_TIMEOUT = 15,
    parameter int INIT_CYC     = 2
) (
    input  logic                clk,
    input  logic                RESET,
    counter_sequencer_if.slave  bus,
    output logic                cnt_RESET,
    output logic                cnt_ENABLE,
    output logic [1:0]          cnt_MODO,
    output logic [WIDTH-1:0]    cnt_D,
    input  logic [WIDTH-1:0]    cnt_Q,
    input  logic                cnt_RCO
);

    state_t           state;
    mode_t            op_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] base_q;
    logic [WIDTH-1:0] remaining;
    logic [7:0]       tick;
    logic [7:0]       rco_cnt;
    logic             rco_prev;

    logic             counting;
    logic [7:0]       rco_next;
    logic [WIDTH-1:0] expected;

    counter_expect #(.WIDTH(WIDTH)) u_expect (
        .op       (op_q),
        .base     (base_q),
        .n        (data_q),
        .expected (expected)
    );

    // Edges are only accumulated while the counter is being driven for the current command.
    assign counting = (state == LOAD) || (state == VERIFY) || (state == RUN) || (state == SETTLE);
    assign rco_next = (counting && cnt_RCO && !rco_prev && (rco_cnt != 8'hFF)) ? rco_cnt + 8'd1 : rco_cnt;

    // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state         <= INIT;
            op_q          <= COUNT_UP;
            data_q        <= '0;
            base_q        <= '0;
            remaining     <= '0;
            tick          <= '0;
            rco_cnt       <= '0;
            rco_prev      <= 1'b0;
            cnt_RESET     <= 1'b0;
            cnt_ENABLE    <= 1'b0;
            cnt_MODO      <= CHARGE;
            cnt_D         <= '0;
            bus.cmd_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_q     <= '0;
            bus.rsp_rco   <= '0;
            bus.rsp_err   <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            rco_prev <= cnt_RCO;
            rco_cnt  <= rco_next;
            case (state)
                INIT: begin
                    if (tick == 8'(INIT_CYC)) begin
                        tick          <= '0;
                        cnt_RESET     <= 1'b0;
                        bus.busy      <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        tick      <= tick + 8'd1;
                        cnt_RESET <= 1'b1;
                        bus.busy  <= 1'b1;
                    end
                end
                IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        op_q          <= mode_t'(bus.cmd_op);
                        data_q        <= bus.cmd_data;
                        base_q        <= cnt_Q;
                        rco_cnt       <= '0;
                        tick          <= '0;
                        bus.cmd_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        if (bus.cmd_op == CHARGE) begin
                            cnt_MODO   <= CHARGE;
                            cnt_D      <= bus.cmd_data;
                            cnt_ENABLE <= 1'b1;
                            state      <= LOAD;
                        end else if (bus.cmd_data == '0) begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_q     <= cnt_Q;
                            bus.rsp_rco   <= '0;
                            bus.rsp_err   <= 1'b0;
                            state         <= DONE;
                        end else begin
                            cnt_MODO   <= bus.cmd_op;
                            cnt_ENABLE <= 1'b1;
                            remaining  <= bus.cmd_data;
                            state      <= RUN;
                        end
                    end
                end
                LOAD: begin
                    cnt_ENABLE <= 1'b0;
                    state      <= VERIFY;
                end
                VERIFY: begin
                    if ((cnt_Q == data_q) || (tick == 8'(LOAD_TIMEOUT - 1))) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_q     <= cnt_Q;
                        bus.rsp_rco   <= rco_next;
                        bus.rsp_err   <= (cnt_Q != data_q);
                        state         <= DONE;
                    end else begin
                        tick <= tick + 8'd1;
                    end
                end
                RUN: begin
                    if (remaining == WIDTH'(1)) begin
                        cnt_ENABLE <= 1'b0;
                        cnt_MODO   <= CHARGE;
                        tick       <= '0;
                        state      <= SETTLE;
                    end else begin
                        remaining <= remaining - WIDTH'(1);
                    end
                end
                SETTLE: begin
                    if (tick == 8'(CNT_LAT - 1)) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_q     <= cnt_Q;
                        bus.rsp_rco   <= rco_next;
                        bus.rsp_err   <= (cnt_Q != expected);
                        state         <= DONE;
                    end else begin
                        tick <= tick + 8'd1;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench: behavioural contador model, arithmetic reference, and a response monitor.
module tb_counter_sequencer;
    import counter_pkg::*;

    typedef struct {
        logic [31:0] q;
        logic [7:0]  rco;
        logic        err;
        int          en;
    } exp_t;

    logic        clk = 1'b0;
    logic        RESET = 1'b0;
    logic        cnt_RESET, cnt_ENABLE;
    logic [1:0]  cnt_MODO;
    logic [31:0] cnt_D;
    logic [31:0] m_q = '0;
    logic        m_rco = 1'b0;
    bit          stuck = 1'b0;
    bit          hold = 1'b0;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0, n_errors = 0, n_rsp = 0, n_push = 0;
    int          en_cnt = 0;
    bit          prev_valid = 1'b0;
    logic [31:0] ref_q = '0;

    mode_t       e_op;
    logic [31:0] e_base, e_n, e_out;

    always #5 clk = ~clk;

    counter_sequencer_if #(.WIDTH(32)) bus ();

    counter_sequencer #(
        .WIDTH(32), .CNT_LAT(2), .LOAD_TIMEOUT(15), .INIT_CYC(2)
    ) dut (
        .clk        (clk),
        .RESET      (RESET),
        .bus        (bus),
        .cnt_RESET  (cnt_RESET),
        .cnt_ENABLE (cnt_ENABLE),
        .cnt_MODO   (cnt_MODO),
        .cnt_D      (cnt_D),
        .cnt_Q      (m_q),
        .cnt_RCO    (m_rco)
    );

    counter_expect #(.WIDTH(32)) u_exp (.op(e_op), .base(e_base), .n(e_n), .expected(e_out));

    // Behavioural contador; "stuck" models a dead counter whose Q stays 0.
    always @(posedge clk) begin
        if (stuck || cnt_RESET) begin
            m_q   <= '0;
            m_rco <= 1'b0;
        end else if (cnt_ENABLE) begin
            case (cnt_MODO)
                2'b00:   begin m_q <= m_q + 32'd1; m_rco <= (m_q == 32'hFFFF_FFFF); end
                2'b01:   begin m_q <= m_q - 32'd1; m_rco <= (m_q == 32'd0); end
                2'b10:   begin m_q <= m_q - 32'd3; m_rco <= (m_q < 32'd3); end
                default: begin m_q <= cnt_D;       m_rco <= 1'b0; end
            endcase
        end else begin
            m_rco <= 1'b0;
        end
    end

    always @(negedge clk) bus.rsp_ready = hold ? 1'b0 : ($urandom_range(0, 2) != 0);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!RESET) begin
            en_cnt     = 0;
            prev_valid = 1'b0;
        end else begin
            if (cnt_ENABLE) en_cnt++;
            if (bus.rsp_valid && !prev_valid) begin
                n_rsp++;
                if (sb.size() == 0) begin
                    check("spurious_rsp", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("rsp_q", bus.rsp_q, mon_e.q);
                    check("rsp_rco", bus.rsp_rco, mon_e.rco);
                    check("rsp_err", bus.rsp_err, mon_e.err);
                    check("enable_cycles", en_cnt, mon_e.en);
                end
                en_cnt = 0;
            end
            prev_valid = bus.rsp_valid;
        end
    end

    // mode 0: normal, 1: abort (no response expected), 2: leave response pending
    task automatic issue(input logic [1:0] op, input logic [31:0] data, input int mode, output int lat);
        exp_t        e;
        logic [63:0] r64, d64, res64, wraps;
        logic [31:0] ideal, actual;
        int          g;
        lat   = 0;
        r64   = {32'd0, ref_q};
        d64   = {32'd0, data};
        wraps = '0;
        if (op == 2'b11) begin
            ideal = data;
            e.en  = 1;
        end else begin
            e.en = int'(data);
            case (op)
                2'b00:   begin res64 = r64 + d64; wraps = res64 >> 32; end
                2'b01:   begin res64 = r64 - d64; wraps = (d64 > r64) ? 64'd1 : 64'd0; end
                default: begin
                    res64 = r64 - 3 * d64;
                    wraps = (3 * d64 > r64) ? (3 * d64 - r64 + 64'hFFFF_FFFF) >> 32 : 64'd0;
                end
            endcase
            ideal = res64[31:0];
        end
        actual = stuck ? 32'd0 : ideal;
        e.q    = actual;
        e.err  = (actual != ideal);
        e.rco  = (stuck || op == 2'b11) ? 8'd0 : ((wraps > 64'd255) ? 8'd255 : wraps[7:0]);

        @(negedge clk);
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        bus.cmd_valid = 1'b1;
        g = 0;
        while (!bus.cmd_ready && g < 400) begin @(negedge clk); g++; end
        if (!bus.cmd_ready) begin
            check("cmd_accept_timeout", 0, 1);
            bus.cmd_valid = 1'b0;
            return;
        end
        if (mode != 1) begin
            sb.push_back(e);
            n_push++;
            ref_q = actual;
        end
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        if (mode == 1) return;
        lat = 1;
        while (!bus.rsp_valid && lat < 400) begin @(negedge clk); lat++; end
        if (!bus.rsp_valid) begin
            check("rsp_timeout", 0, 1);
            return;
        end
        if (mode == 2) return;
        g = 0;
        while (bus.rsp_valid && g < 400) begin @(negedge clk); g++; end
        if (bus.rsp_valid) check("rsp_drain_timeout", 0, 1);
    endtask

    task automatic check_init();
        int n = 0, g = 0;
        while (!bus.cmd_ready && g < 20) begin
            @(negedge clk);
            g++;
            if (cnt_RESET) n++;
        end
        check("init_cycles", n, 2);
        check("init_cmd_ready", bus.cmd_ready, 1);
        check("init_rsp_valid", bus.rsp_valid, 0);
        check("init_rsp_q", bus.rsp_q, 0);
        check("init_rsp_rco", bus.rsp_rco, 0);
        check("init_rsp_err", bus.rsp_err, 0);
        check("init_busy", bus.busy, 0);
        ref_q = '0;
    endtask

    task automatic check_in_reset();
        check("rst_modo", cnt_MODO, 2'b11);
        check("rst_enable", cnt_ENABLE, 0);
        check("rst_cnt_reset", cnt_RESET, 0);
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_cnt_d", cnt_D, 0);
    endtask

    initial begin
        int          lat;
        int          r;
        logic [1:0]  op;
        logic [31:0] val;
        logic [63:0] ref64;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_data  = '0;

        for (int i = 0; i < 8; i++) begin
            e_op   = mode_t'($urandom_range(0, 2));
            e_base = (i == 0) ? 32'hFFFF_FFFF : $urandom;
            e_n    = (i == 1) ? 32'hFFFF_FFFF : $urandom;
            #1;
            case (e_op)
                COUNT_UP:   ref64 = {32'd0, e_base} + {32'd0, e_n};
                COUNT_DOWN: ref64 = {32'd0, e_base} - {32'd0, e_n};
                default:    ref64 = {32'd0, e_base} - 3 * {32'd0, e_n};
            endcase
            check("expect_unit", e_out, ref64[31:0]);
        end

        repeat (3) @(negedge clk);
        check_in_reset();
        RESET = 1'b1;
        check_init();

        issue(2'b11, 32'h0000_00F0, 0, lat);
        check("load_latency", lat, 3);
        issue(2'b00, 32'h0000_0020, 0, lat);
        check("up32_latency", lat, 35);
        issue(2'b11, 32'hFFFF_FFFE, 0, lat);
        issue(2'b00, 32'd3, 0, lat);
        issue(2'b11, 32'h0000_0010, 0, lat);
        issue(2'b10, 32'd6, 0, lat);
        issue(2'b01, 32'd0, 0, lat);
        check("n0_latency", lat, 1);
        issue(2'b11, 32'h0000_0001, 0, lat);
        issue(2'b01, 32'd2, 0, lat);

        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            if (r < 3) begin
                case ($urandom_range(0, 2))
                    0:       val = $urandom;
                    1:       val = 32'hFFFF_FFFF - $urandom_range(0, 20);
                    default: val = $urandom_range(0, 20);
                endcase
                issue(2'b11, val, 0, lat);
            end else begin
                op = 2'($urandom_range(0, 2));
                val = (r == 3) ? 32'd0 : 32'($urandom_range(1, 40));
                issue(op, val, 0, lat);
            end
        end

        hold = 1'b1;
        repeat (2) @(negedge clk);
        issue(2'b11, 32'hA5A5_5A5A, 2, lat);
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = 32'd5;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_cmd_ready", bus.cmd_ready, 0);
            check("hold_rsp_valid", bus.rsp_valid, 1);
            check("hold_rsp_q", bus.rsp_q, 32'hA5A5_5A5A);
            check("hold_rsp_err", bus.rsp_err, 0);
            check("hold_busy", bus.busy, 1);
        end
        bus.cmd_valid = 1'b0;
        hold = 1'b0;
        r = 0;
        while (bus.rsp_valid && r < 100) begin @(negedge clk); r++; end
        check("hold_release", bus.rsp_valid, 0);

        @(negedge clk);
        stuck = 1'b1;
        @(negedge clk);
        ref_q = '0;
        issue(2'b11, 32'h1234_5678, 0, lat);
        check("stuck_load_latency", lat, 17);
        issue(2'b00, 32'd4, 0, lat);
        stuck = 1'b0;

        issue(2'b00, 32'd30, 1, lat);
        repeat (5) @(negedge clk);
        check("abort_enable", cnt_ENABLE, 1);
        RESET = 1'b0;
        @(negedge clk);
        check_in_reset();
        RESET = 1'b1;
        check_init();
        issue(2'b11, 32'h0000_0055, 0, lat);
        issue(2'b01, 32'd5, 0, lat);

        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        check("rsp_count", n_rsp, n_push);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
